// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: format codes, FSM states, fixed opcodes and range helper
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_S  = 3'd1,
        FMT_B  = 3'd2,
        FMT_J  = 3'd3,
        FMT_U  = 3'd4,
        FMT_LI = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        LI_HI = 2'd2
    } state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [6:0]  OP_IMM = 7'b0010011;

    function automatic logic fits_signed(input logic [31:0] v, input int w);
        logic [31:0] s;
        s = $signed(v) >>> (w - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_imm.sv
// imm_pack: scatters an immediate into its instruction bit positions and flags range errors
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic        shift,
    input  logic [31:0] imm,
    output logic [31:0] bits,
    output logic        err
);

    always_comb begin
        bits = '0;
        err  = 1'b0;
        case (fmt)
            FMT_I: begin
                bits[31:20] = imm[11:0];
                err         = shift ? (imm[31:5] != '0) : !fits_signed(imm, 12);
            end
            FMT_S: begin
                bits[31:25] = imm[11:5];
                bits[11:7]  = imm[4:0];
                err         = !fits_signed(imm, 12);
            end
            FMT_B: begin
                bits[31]    = imm[12];
                bits[30:25] = imm[10:5];
                bits[11:8]  = imm[4:1];
                bits[7]     = imm[11];
                err         = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J: begin
                bits[31]    = imm[20];
                bits[30:21] = imm[10:1];
                bits[20]    = imm[11];
                bits[19:12] = imm[19:12];
                err         = !fits_signed(imm, 21) || imm[0];
            end
            FMT_U: begin
                bits[31:12] = imm[31:12];
                err         = imm[11:0] != '0;
            end
            FMT_LI: err = 1'b0;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into RV32I words, expanding LI into LUI+ADDI
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ERR_NOP = 0,
    parameter int LI_OPT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    state_e      state, state_d;
    logic [31:0] pend, instr_d, bits, regs, packed_w, enc, lui_w, addi0_w, addi_rd_w;
    logic [19:0] hi;
    logic [11:0] lo;
    logic        ierr, err_d, shift, acc, ld_pend, is_li, one_addi, one_lui, li_two;
    logic        use_rd, use_rs1, use_rs2;

    assign shift = (in_fmt == FMT_I) && (in_opcode == OP_IMM) && (in_funct3[1:0] == 2'b01);

    imm_pack u_imm (
        .fmt   (in_fmt),
        .shift (shift),
        .imm   (in_imm),
        .bits  (bits),
        .err   (ierr)
    );

    assign use_rd   = (in_fmt == FMT_I) || (in_fmt == FMT_J) || (in_fmt == FMT_U);
    assign use_rs1  = (in_fmt == FMT_I) || (in_fmt == FMT_S) || (in_fmt == FMT_B);
    assign use_rs2  = (in_fmt == FMT_S) || (in_fmt == FMT_B);
    assign regs     = {7'd0, use_rs2 ? in_rs2 : 5'd0, use_rs1 ? in_rs1 : 5'd0,
                       use_rs1 ? in_funct3 : 3'd0, use_rd ? in_rd : 5'd0, in_opcode};
    assign packed_w = {shift ? in_funct7 : bits[31:25], bits[24:0]} | regs;
    assign enc      = (ierr && ERR_NOP != 0) ? NOP : packed_w;

    // ADDI sign-extends lo, so the upper part absorbs lo[11] to compensate
    assign lo        = in_imm[11:0];
    assign hi        = in_imm[31:12] + {19'd0, lo[11]};
    assign lui_w     = {hi, in_rd, OP_LUI};
    assign addi0_w   = {lo, 5'd0, 3'd0, in_rd, OP_IMM};
    assign addi_rd_w = {lo, in_rd, 3'd0, in_rd, OP_IMM};
    assign one_addi  = (LI_OPT != 0) && (hi == '0);
    assign one_lui   = (LI_OPT != 0) && (lo == '0);
    assign li_two    = !one_addi && !one_lui;
    assign is_li     = in_fmt == FMT_LI;

    assign out_valid = state != IDLE;
    assign in_ready  = (state != LI_HI) && (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign ld_pend   = (state == LI_HI) && out_ready;

    always_comb begin
        state_d = ld_pend ? HOLD
                : acc ? ((is_li && li_two) ? LI_HI : HOLD)
                : (state == HOLD && out_ready) ? IDLE : state;
        instr_d = ld_pend ? pend
                : acc ? (is_li ? (one_addi ? addi0_w : lui_w) : enc) : out_instr;
        err_d   = ld_pend ? 1'b0 : acc ? (!is_li && ierr) : out_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_instr <= '0;
            out_err   <= 1'b0;
            pend      <= '0;
        end else begin
            state     <= state_d;
            out_instr <= instr_d;
            out_err   <= err_d;
            if (acc) pend <= addi_rd_w;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus LI, backpressure, reset and round-trip sequences
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, instr;
        logic        err, chk;
    } vec_t;

    logic        clk = 0, rst = 1, oready = 1;
    logic [2:0]  iv = '0, ir, ov, oe;
    logic [2:0]  fmt = '0, f3 = '0;
    logic [6:0]  op = '0, f7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic [31:0] oi [3];
    logic [31:0] hs [$];
    vec_t        tbl [$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    instr_encoder dut0 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_fmt(fmt),
        .in_opcode(op), .in_funct3(f3), .in_funct7(f7), .in_rd(rd), .in_rs1(rs1),
        .in_rs2(rs2), .in_imm(imm), .out_valid(ov[0]), .out_ready(oready),
        .out_instr(oi[0]), .out_err(oe[0])
    );

    instr_encoder #(.ERR_NOP(1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_fmt(fmt),
        .in_opcode(op), .in_funct3(f3), .in_funct7(f7), .in_rd(rd), .in_rs1(rs1),
        .in_rs2(rs2), .in_imm(imm), .out_valid(ov[1]), .out_ready(oready),
        .out_instr(oi[1]), .out_err(oe[1])
    );

    instr_encoder #(.LI_OPT(0)) dut2 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_fmt(fmt),
        .in_opcode(op), .in_funct3(f3), .in_funct7(f7), .in_rd(rd), .in_rs1(rs1),
        .in_rs2(rs2), .in_imm(imm), .out_valid(ov[2]), .out_ready(oready),
        .out_instr(oi[2]), .out_err(oe[2])
    );

    always @(posedge clk) if (!rst && ov[0] && oready) hs.push_back(oi[0]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] a_fmt, input logic [6:0] a_op, input logic [2:0] a_f3,
                       input logic [6:0] a_f7, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                       input logic [4:0] a_rs2, input logic [31:0] a_imm, input logic [31:0] a_instr,
                       input logic a_err, input logic a_chk);
        vec_t v;
        v.fmt = a_fmt; v.op = a_op; v.f3 = a_f3; v.f7 = a_f7; v.rd = a_rd; v.rs1 = a_rs1;
        v.rs2 = a_rs2; v.imm = a_imm; v.instr = a_instr; v.err = a_err; v.chk = a_chk;
        tbl.push_back(v);
    endtask

    task automatic set(input vec_t v);
        fmt = v.fmt; op = v.op; f3 = v.f3; f7 = v.f7; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input int k);
        int n = 0;
        iv[k] = 1'b1;
        while (!ir[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: dut%0d in_ready got 0 expected 1", k);
        end
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0: return {{20{w[31]}}, w[31:20]};
            3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return {w[31:12], 12'd0};
        endcase
    endfunction

    function automatic logic exp_err(input logic [2:0] f, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (f)
            3'd0, 3'd1: return s < -2048 || s > 2047;
            3'd2: return s < -4096 || s > 4094 || v[0];
            3'd3: return s < -1048576 || s > 1048574 || v[0];
            default: return v[11:0] != 12'd0;
        endcase
    endfunction

    initial begin
        vec_t        v;
        logic [6:0]  ops [5];
        logic [31:0] a, b;
        ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
        add(0, 7'h13, 0, 0, 5, 6, 0, 32'hFFFF_FFFF, 32'hFFF3_0293, 0, 1);
        add(0, 7'h13, 0, 0, 1, 0, 0, 32'd2047,      32'h7FF0_0093, 0, 1);
        add(0, 7'h13, 0, 0, 1, 0, 0, 32'd2048,      32'h8000_0093, 1, 1);
        add(0, 7'h13, 0, 0, 1, 0, 0, 32'hFFFF_F800, 32'h8000_0093, 0, 1);
        add(1, 7'h23, 2, 0, 0, 2, 3, 32'd8,         32'h0031_2423, 0, 1);
        add(1, 7'h23, 2, 0, 0, 2, 3, 32'hFFFF_F7FF, 32'h7E31_2FA3, 1, 1);
        add(2, 7'h63, 0, 0, 0, 1, 2, 32'd4094,      32'h7E20_8FE3, 0, 1);
        add(2, 7'h63, 0, 0, 0, 1, 2, 32'hFFFF_F000, 32'h8020_8063, 0, 1);
        add(2, 7'h63, 0, 0, 0, 1, 2, 32'd4096,      32'h8020_8063, 1, 1);
        add(2, 7'h63, 0, 0, 0, 1, 2, 32'd3,         32'h0020_8163, 1, 1);
        add(3, 7'h6F, 0, 0, 1, 0, 0, 32'd2048,      32'h0010_00EF, 0, 1);
        add(3, 7'h6F, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 0, 1);
        add(3, 7'h6F, 0, 0, 1, 0, 0, 32'h0010_0000, 32'h8000_00EF, 1, 1);
        add(4, 7'h37, 0, 0, 5, 0, 0, 32'hABCD_E000, 32'hABCD_E2B7, 0, 1);
        add(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5678, 32'h1234_52B7, 1, 1);
        add(0, 7'h13, 5, 7'h20, 5, 6, 0, 32'd3,     32'h4033_5293, 0, 1);
        add(0, 7'h13, 5, 7'h20, 5, 6, 0, 32'd32,    32'h4003_5293, 1, 1);
        add(6, 7'h13, 0, 0, 5, 6, 0, 32'd0,         32'h0,         1, 0);
        add(7, 7'h13, 0, 0, 5, 6, 0, 32'd0,         32'h0,         1, 0);
        add(5, 7'h00, 0, 0, 5, 0, 0, 32'h0000_07FF, 32'h7FF0_0293, 0, 1);
        add(5, 7'h00, 0, 0, 5, 0, 0, 32'hABCD_E000, 32'hABCD_E2B7, 0, 1);
        add(5, 7'h00, 0, 0, 5, 0, 0, 32'hFFFF_F800, 32'h8000_0293, 0, 1);
        add(5, 7'h00, 0, 0, 5, 0, 0, 32'h0,         32'h0000_0293, 0, 1);

        repeat (2) @(negedge clk);
        check("rst_valid", {29'd0, ov}, 32'd0);
        check("rst_instr", oi[0], 32'd0);
        check("rst_err", {29'd0, oe}, 32'd0);
        check("rst_ready", {29'd0, ir}, 32'd7);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            set(tbl[i]);
            push(0);
            if (tbl[i].chk) check($sformatf("vec%0d_instr", i), oi[0], tbl[i].instr);
            check($sformatf("vec%0d_err", i), {31'd0, oe[0]}, {31'd0, tbl[i].err});
            check($sformatf("vec%0d_valid", i), {31'd0, ov[0]}, 32'd1);
        end
        @(negedge clk);

        v = tbl[0]; v.fmt = 3'd5; v.rd = 5; v.imm = 32'h1234_5FFF;
        set(v);
        push(0);
        check("li2_lui", oi[0], 32'h1234_62B7);
        check("li2_ready_low", {31'd0, ir[0]}, 32'd0);
        @(negedge clk);
        check("li2_addi", oi[0], 32'hFFF2_8293);
        check("li2_err", {31'd0, oe[0]}, 32'd0);
        @(negedge clk);

        set(tbl[8]);
        push(1);
        check("nop_instr", oi[1], 32'h0000_0013);
        check("nop_err", {31'd0, oe[1]}, 32'd1);
        @(negedge clk);

        set(tbl[19]);
        push(2);
        check("lio0_lui", oi[2], 32'h0000_02B7);
        @(negedge clk);
        check("lio0_addi", oi[2], 32'h7FF2_8293);
        @(negedge clk);

        hs.delete();
        set(tbl[0]);
        push(0);
        a = oi[0];
        oready = 1'b0;
        set(tbl[1]);
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), oi[0], 32'hFFF3_0293);
            check($sformatf("bp_ready%0d", i), {31'd0, ir[0]}, 32'd0);
        end
        oready = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        b = oi[0];
        check("bp_next", b, 32'h7FF0_0093);
        @(negedge clk);
        check("bp_count", hs.size(), 32'd2);
        if (hs.size() == 2) begin
            check("bp_first", hs[0], a);
            check("bp_second", hs[1], 32'h7FF0_0093);
        end

        oready = 1'b0;
        v.fmt = 3'd5; v.imm = 32'h1234_5FFF;
        set(v);
        push(0);
        check("rli_lui", oi[0], 32'h1234_62B7);
        rst = 1'b1;
        @(negedge clk);
        check("rli_valid", {31'd0, ov[0]}, 32'd0);
        check("rli_ready", {31'd0, ir[0]}, 32'd1);
        rst = 1'b0;
        hs.delete();
        oready = 1'b1;
        repeat (3) @(negedge clk);
        check("rli_no_addi", hs.size(), 32'd0);

        for (int i = 0; i < 400; i++) begin
            v.fmt = 3'($urandom_range(0, 4));
            v.op = ops[v.fmt];
            v.f3 = 3'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
            v.imm = 32'($signed($urandom) >>> $urandom_range(31, 10));
            if (v.fmt == 3'd4 && $urandom_range(0, 1) == 1) v.imm[11:0] = 12'd0;
            if ($urandom_range(0, 1) == 1) v.imm[0] = 1'b0;
            set(v);
            push(0);
            check($sformatf("rand%0d_err", i), {31'd0, oe[0]}, {31'd0, exp_err(v.fmt, v.imm)});
            if (!oe[0]) check($sformatf("rand%0d_ext", i), extend(v.fmt, oi[0]), v.imm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
